// File: rtl/pipe_sched_pkg.sv
// Shared definitions for the pipelined-adder scheduler.
//   ADD_LAT   : adder pipeline depth (req -> vld)
//   ADD_W     : adder operand/result width
//   TAG_MAX_W : tag field width carried in the shadow pipeline (covers N <= 8)
//   tag_w()   : tag width needed to index N requesters
//   tag_stage_t : one stage of the shadow tag pipeline
package pipe_sched_pkg;
    localparam int ADD_LAT   = 3;
    localparam int ADD_W     = 32;
    localparam int TAG_MAX_W = 3;

    function automatic int tag_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
    } tag_stage_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant on the first requester at or above the
// pointer (wrapping); the pointer moves past the winner whenever a grant is given.
//   clk, reset    : clock, async active-high reset (pointer -> 0)
//   en_i          : grant enable; no grant and no pointer move when low
//   req_i[N]      : requests
//   gnt_o[N]      : one-hot grant
//   gnt_idx_o[TW] : index of the granted requester (0 when no grant)
module rr_arbiter
    import pipe_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int TW = tag_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [TW-1:0] gnt_idx_o
);
    logic [TW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] idx;
    logic          found;
    int            j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        ptr_d     = ptr_q;
        found     = 1'b0;
        idx       = '0;
        j         = 0;
        if (en_i) begin
            for (int k = 0; k < N; k++) begin
                j = int'(ptr_q) + k;
                if (j >= N) j = j - N;
                idx = TW'(j);
                if (!found && req_i[idx]) begin
                    found      = 1'b1;
                    gnt_o[idx] = 1'b1;
                    gnt_idx_o  = idx;
                    ptr_d      = (idx == TW'(N-1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/pipe_adder_sched.sv
// Shares one LAT-stage pipelined adder between N requesters. Each cycle a
// round-robin winner is issued to the adder; its index rides a shadow tag
// pipeline so the returning sum lands in that requester's result register.
//   clk, reset          : clock, async active-high reset
//   in_vld/in_rdy[N]    : operation handshake (in_rdy one-hot grant)
//   in_x_0/in_x_1[N*W]  : packed operands, requester i at [i*W +: W]
//   out_vld/out_rdy[N]  : result handshake; out_data[N*W] packed results
//   abort[N]            : one-cycle pulse for ops dropped by flush
//   stall, flush        : global pipeline freeze / kill (flush wins)
//   add_*               : connection to the shared adder
module pipe_adder_sched
    import pipe_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = ADD_W,
    parameter int LAT = ADD_LAT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   in_vld,
    input  logic [N*W-1:0] in_x_0,
    input  logic [N*W-1:0] in_x_1,
    output logic [N-1:0]   in_rdy,
    output logic [N-1:0]   out_vld,
    output logic [N*W-1:0] out_data,
    input  logic [N-1:0]   out_rdy,
    output logic [N-1:0]   abort,
    input  logic           stall,
    input  logic           flush,
    output logic           add_req,
    output logic [W-1:0]   add_x_0,
    output logic [W-1:0]   add_x_1,
    output logic           add_stall,
    output logic           add_flush,
    input  logic [W-1:0]   add_result,
    input  logic           add_vld
);
    localparam int TW = tag_w(N);

    logic [N-1:0][W-1:0] x0_v, x1_v, out_data_q, out_data_d;
    logic [N-1:0]        inflight_q, inflight_d, out_vld_q, out_vld_d;
    logic [N-1:0]        abort_q, abort_d, busy, elig, gnt;
    logic [TW-1:0]       g;
    tag_stage_t [LAT-1:0] tag_q, tag_d;
    logic                ret;

    assign x0_v = in_x_0;
    assign x1_v = in_x_1;

    // One op outstanding per requester: busy until its result is consumed.
    assign busy = inflight_q | out_vld_q;
    assign elig = in_vld & ~busy;

    // Reset gates the grant so in_rdy reads 0 while reset is held.
    rr_arbiter #(.N(N), .TW(TW)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .en_i     (~stall & ~flush & ~reset),
        .req_i    (elig),
        .gnt_o    (gnt),
        .gnt_idx_o(g)
    );

    assign in_rdy    = gnt;
    assign add_req   = |gnt;
    assign add_x_0   = add_req ? x0_v[g] : '0;
    assign add_x_1   = add_req ? x1_v[g] : '0;
    assign add_stall = stall;
    assign add_flush = flush;

    // The adder holds vld while stalled, so only unstalled returns count;
    // a return coinciding with flush is dropped and reported via abort.
    assign ret = ~stall & ~flush & add_vld & tag_q[LAT-1].valid;

    always_comb begin
        tag_d      = tag_q;
        inflight_d = inflight_q;
        out_vld_d  = out_vld_q & ~out_rdy;
        out_data_d = out_data_q;
        abort_d    = '0;
        if (flush) begin
            tag_d      = '0;
            inflight_d = '0;
            abort_d    = inflight_q;
        end else if (!stall) begin
            for (int s = LAT-1; s > 0; s--) tag_d[s] = tag_q[s-1];
            tag_d[0].valid = add_req;
            tag_d[0].tag   = TAG_MAX_W'(g);
            for (int i = 0; i < N; i++) begin
                if (ret && tag_q[LAT-1].tag == TAG_MAX_W'(i)) begin
                    out_vld_d[i]  = 1'b1;
                    out_data_d[i] = add_result;
                    inflight_d[i] = 1'b0;
                end
            end
            if (add_req) inflight_d[g] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q      <= '0;
            inflight_q <= '0;
            out_vld_q  <= '0;
            out_data_q <= '0;
            abort_q    <= '0;
        end else begin
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            abort_q    <= abort_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign abort    = abort_q;

    // A result with no matching tag means the adder and shadow pipe disagree.
    a_ret_has_tag: assert property (@(posedge clk) disable iff (reset)
        (add_vld && !stall) |-> tag_q[LAT-1].valid);
endmodule

// File: tb/tb_pipe_adder_sched.sv
// Testbench for pipe_adder_sched: vector table, directed multi-cycle
// sequences (throughput, stall, flush, async reset) and a randomized run
// against a latency-counting reference model. Includes a behavioural adder.
module tb_pipe_adder_sched;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   in_vld = '0, out_rdy = '0;
    logic [N*W-1:0] in_x_0 = '0, in_x_1 = '0;
    logic           stall = 1'b0, flush = 1'b0;
    logic [N-1:0]   in_rdy, out_vld, abort;
    logic [N*W-1:0] out_data;
    logic           add_req, add_stall, add_flush, add_vld;
    logic [W-1:0]   add_x_0, add_x_1, add_result;

    int nchk = 0, npass = 0;

    always #5 clk = ~clk;

    pipe_adder_sched #(.N(N), .W(W), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .in_vld(in_vld), .in_x_0(in_x_0), .in_x_1(in_x_1),
        .in_rdy(in_rdy), .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy),
        .abort(abort), .stall(stall), .flush(flush), .add_req(add_req),
        .add_x_0(add_x_0), .add_x_1(add_x_1), .add_stall(add_stall),
        .add_flush(add_flush), .add_result(add_result), .add_vld(add_vld)
    );

    // Behavioural LAT-deep adder: holds on stall, kills on flush.
    logic [W-1:0]   a_s [LAT];
    logic [LAT-1:0] a_v;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_v <= '0;
            for (int s = 0; s < LAT; s++) a_s[s] <= '0;
        end else if (add_flush) begin
            a_v <= '0;
        end else if (!add_stall) begin
            a_v    <= {a_v[LAT-2:0], add_req};
            a_s[0] <= add_x_0 + add_x_1;
            for (int s = 1; s < LAT; s++) a_s[s] <= a_s[s-1];
        end
    end
    assign add_vld    = a_v[LAT-1];
    assign add_result = a_s[LAT-1];

    task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic logic [W-1:0] od(input int i);
        return out_data[i*W +: W];
    endfunction

    task automatic setx(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        in_x_0[i*W +: W] = a;
        in_x_1[i*W +: W] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_vld = '0; out_rdy = '0; stall = 1'b0; flush = 1'b0;
        in_x_0 = '0; in_x_1 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        int           r;
        logic [W-1:0] a, b, s;
    } vec_t;
    vec_t vt[6];

    // Reference model state for the random run.
    int           st[N];   // 0 idle, 1 in flight, 2 result pending
    int           rem[N];  // unstalled edges left until result
    logic [W-1:0] md[N], pend[N];
    int           ptr;

    initial begin
        vt[0] = '{0, 32'h000000FF, 32'h00000001, 32'h00000100};
        vt[1] = '{1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vt[2] = '{2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        vt[3] = '{3, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568};
        vt[4] = '{0, 32'h80000000, 32'h80000000, 32'h00000000};
        vt[5] = '{1, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF};

        // Reset state, with every requester asking.
        #1 reset = 1'b1;
        in_vld = '1;
        #2;
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_abort", abort, 0);
        chk("rst_add_req", add_req, 0);
        do_reset();

        // Single ops from the table: latency, no re-grant until consumed.
        for (int v = 0; v < 6; v++) begin
            int r;
            r = vt[v].r;
            step();
            in_vld = oh(r); out_rdy = '0;
            setx(r, vt[v].a, vt[v].b);
            #1;
            chk($sformatf("v%0d_grant", v), in_rdy, oh(r));
            chk($sformatf("v%0d_add_x0", v), add_x_0, vt[v].a);
            for (int c = 1; c <= 5; c++) begin
                step(); #1;
                chk($sformatf("v%0d_noregrant_c%0d", v, c), in_rdy, 0);
                chk($sformatf("v%0d_out_vld_c%0d", v, c), out_vld, (c >= 4) ? oh(r) : '0);
                if (c == 4) chk($sformatf("v%0d_sum", v), od(r), vt[v].s);
            end
            out_rdy = oh(r); in_vld = '0;
            step(); #1;
            chk($sformatf("v%0d_consumed", v), out_vld, 0);
            chk($sformatf("v%0d_data_hold", v), od(r), vt[v].s);
            out_rdy = '0;
        end

        // All four requesting continuously.
        do_reset();
        begin
            logic [N-1:0] er [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4};
            logic [N-1:0] ov [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
            for (int c = 0; c < 8; c++) begin
                step();
                if (c == 0) begin
                    in_vld = '1; out_rdy = '1;
                    for (int i = 0; i < N; i++) setx(i, W'(i), 32'h10);
                end
                #1;
                chk($sformatf("rr_rdy_c%0d", c), in_rdy, er[c]);
                chk($sformatf("rr_vld_c%0d", c), out_vld, ov[c]);
                if (c >= 4) chk($sformatf("rr_data_c%0d", c), od(c-4), 32'h10 + W'(c-4));
            end
            step(); in_vld = '0;
            repeat (8) step();
        end

        // Two stall cycles with three ops in flight.
        do_reset();
        begin
            logic [N-1:0] er [10] = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4};
            logic [N-1:0] ov [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
            for (int c = 0; c < 10; c++) begin
                step();
                if (c == 0) begin
                    in_vld = '1; out_rdy = '1;
                    for (int i = 0; i < N; i++) setx(i, 32'h100 + W'(i), 32'hF0);
                end
                stall = (c == 3 || c == 4);
                #1;
                chk($sformatf("st_rdy_c%0d", c), in_rdy, er[c]);
                chk($sformatf("st_vld_c%0d", c), out_vld, ov[c]);
                if (c >= 6) chk($sformatf("st_data_c%0d", c), od(c-6), 32'h1F0 + W'(c-6));
            end
            step(); in_vld = '0;
            repeat (8) step();
        end

        // Flush with 1 and 2 in flight while 0 holds an unconsumed result.
        do_reset();
        begin
            logic [N-1:0] iv [11] = '{4'h1, 4'h6, 4'h6, 4'h0, 4'h8, 4'h6, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
            logic [N-1:0] er [11] = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
            logic [N-1:0] ov [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h3, 4'h7};
            logic [N-1:0] ab [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
            for (int c = 0; c < 11; c++) begin
                step();
                if (c == 0) for (int i = 0; i < N; i++) setx(i, 32'h1000 * W'(i+1), 32'h5);
                in_vld = iv[c];
                flush = (c == 4);
                #1;
                chk($sformatf("fl_rdy_c%0d", c), in_rdy, er[c]);
                chk($sformatf("fl_vld_c%0d", c), out_vld, ov[c]);
                chk($sformatf("fl_abort_c%0d", c), abort, ab[c]);
            end
            chk("fl_data0", od(0), 32'h1005);
            chk("fl_data1", od(1), 32'h2005);
            chk("fl_data2", od(2), 32'h3005);
            step(); out_rdy = '1;
            repeat (8) step();
        end

        // Asynchronous reset in the middle of a burst.
        step(); in_vld = '1; out_rdy = '1;
        for (int i = 0; i < N; i++) setx(i, W'(i), W'(7));
        repeat (5) step();
        #2 reset = 1'b1;
        #1;
        chk("ar_in_rdy", in_rdy, 0);
        chk("ar_out_vld", out_vld, 0);
        chk("ar_out_data", out_data, 0);
        chk("ar_abort", abort, 0);
        chk("ar_add_req", add_req, 0);
        step(); step();
        reset = 1'b0;
        #1;
        chk("ar_first_grant", in_rdy, oh(0));

        // Randomized run against the reference model.
        do_reset();
        ptr = 0;
        for (int i = 0; i < N; i++) begin st[i] = 0; rem[i] = 0; md[i] = '0; pend[i] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int             eg;
            logic [N*W-1:0] ed;
            logic [N-1:0]   ev;
            step();
            in_vld  = N'($urandom);
            out_rdy = N'($urandom);
            stall   = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) setx(i, $urandom, $urandom);
            #1;
            eg = -1;
            if (!stall)
                for (int k = 0; k < N; k++)
                    if (eg < 0 && in_vld[(ptr+k)%N] && st[(ptr+k)%N] == 0) eg = (ptr+k)%N;
            ev = '0;
            for (int i = 0; i < N; i++) begin
                ed[i*W +: W] = md[i];
                ev[i] = (st[i] == 2);
            end
            chk($sformatf("rnd_rdy_%0d", cyc), in_rdy, (eg < 0) ? '0 : oh(eg));
            chk($sformatf("rnd_vld_%0d", cyc), out_vld, ev);
            chk($sformatf("rnd_data_%0d", cyc), out_data, ed);
            // Advance the model across the coming edge.
            for (int i = 0; i < N; i++)
                if (st[i] == 2 && out_rdy[i]) st[i] = 0;
            if (!stall)
                for (int i = 0; i < N; i++)
                    if (st[i] == 1) begin
                        rem[i]--;
                        if (rem[i] == 0) begin st[i] = 2; md[i] = pend[i]; end
                    end
            if (eg >= 0) begin
                st[eg]   = 1;
                rem[eg]  = LAT;
                pend[eg] = in_x_0[eg*W +: W] + in_x_1[eg*W +: W];
                ptr      = (eg + 1) % N;
            end
        end
        step(); in_vld = '0; stall = 1'b0; out_rdy = '1;
        repeat (6) step();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
